// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// counter sizing and FSM state encoding.
package seq_divider_pkg;

  localparam int DIV_W = 4;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the divider. The requester drives start/a/b;
// the divider drives busy/done/q/r/div0.
interface seq_divider_if #(parameter int W = seq_divider_pkg::DIV_W);

  // Handshake: start is sampled on a rising edge only while busy=0. The divider
  // then raises busy until it finishes, and done pulses for exactly one cycle
  // with q/r/div0 valid. start may be held through the done cycle to chain the
  // next operation without an idle cycle.
  logic           start;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] q;
  logic [W-1:0]   r;
  logic           div0;

  modport master (output start, a, b, input busy, done, q, r, div0);
  modport slave  (input start, a, b, output busy, done, q, r, div0);

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   p_i,
  input  logic         bit_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   p_next_o,
  output logic         qbit_o
);

  logic [W:0] p_sh;
  logic       unused_p_msb;

  // p never exceeds the divisor after a step, so its top bit is always shifted out.
  assign unused_p_msb = p_i[W];
  assign p_sh         = {p_i[W-1:0], bit_i};

  always_comb begin
    p_next_o = p_sh;
    qbit_o   = 1'b0;
    if (p_sh >= {1'b0, b_i}) begin
      p_next_o = p_sh - {1'b0, b_i};
      qbit_o   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, 2W-bit dividend / W-bit divisor, one quotient
// bit per clock. Optional macro SEQ_DIVIDER_DIV0_EN adds a divide-by-zero fast path.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  seq_divider_if.slave       bus,
  output logic [1:0]         state_o
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * W);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] aq_q, aq_d;
  logic [W:0]     p_q, p_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic           div0_q, div0_d;
  logic [W:0]     p_step;
  logic           qbit;
  logic           accept;

  div_step #(.W(W)) u_step (
    .p_i      (p_q),
    .bit_i    (aq_q[2*W-1]),
    .b_i      (b_q),
    .p_next_o (p_step),
    .qbit_o   (qbit)
  );

  assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_FIN));

  // aq_q holds the dividend; it shifts out MSB-first while quotient bits fill
  // in from the LSB, so after 2W steps it holds the quotient.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aq_d    = aq_q;
    p_d     = p_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    case (state_q)
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
          q_d     = aq_q;
          r_d     = p_q[W-1:0];
`ifdef SEQ_DIVIDER_DIV0_EN
          div0_d  = (b_q == '0);
`endif
        end else begin
          aq_d  = {aq_q[2*W-2:0], qbit};
          p_d   = p_step;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_CALC;
      aq_d    = bus.a;
      p_d     = '0;
      b_d     = bus.b;
      cnt_d   = '0;
      div0_d  = 1'b0;
`ifdef SEQ_DIVIDER_DIV0_EN
      // Preload the natural zero-divisor result and commit on the next edge.
      if (bus.b == '0) begin
        aq_d  = '1;
        p_d   = {1'b0, bus.a[W-1:0]};
        cnt_d = CNT_LAST;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      aq_q    <= '0;
      p_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aq_q    <= aq_d;
      p_q     <= p_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.busy = (state_q == S_CALC);
  assign bus.done = (state_q == S_FIN);
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.div0 = div0_q;
  assign state_o  = state_q;

endmodule
